mem_wb_skid: RTL and testbench

MEM_WB_SKID -- requirements
Module: mem_wb_skid

---
 rtl/mem_wb_skid.sv | 100 ++++++++++
 tb/tb_mem_wb_skid.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline boundary: a two-entry (head + skid) FIFO whose ready is registered-only.
// Drives the register-file write strobe and counts retired entries.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rd_data,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              in_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_rd_data,
    output logic [ADDR_W-1:0] wb_rd_addr,
    output logic              wb_we,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           head_q;
    entry_t           skid_q;
    entry_t           in_entry;
    logic [1:0]       occ_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             retire;

    assign in_entry = {in_rd_en, in_rd_addr, in_rd_data};

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = rdy && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid && in_ready && !flush;
    assign retire    = rdy && out_valid && out_ready && !flush;
    assign wb_we     = rdy && out_valid && out_ready && head_q.en && (head_q.addr != '0);

    assign wb_rd_data = head_q.data;
    assign wb_rd_addr = head_q.addr;
    assign occupancy  = occ_q;
    assign retire_cnt = cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: entry payloads are reset and cleared on emptying, because an empty head must read as zero.
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else if (rdy) begin
            if (flush) begin
                occ_q  <= 2'd0;
                head_q <= '0;
                skid_q <= '0;
            end else begin
                if (retire) cnt_q <= cnt_q + CNT_W'(1);
                case (occ_q)
                    2'd0: begin
                        if (accept) begin
                            head_q <= in_entry;
                            occ_q  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (accept && retire) begin
                            head_q <= in_entry;
                        end else if (accept) begin
                            skid_q <= in_entry;
                            occ_q  <= 2'd2;
                        end else if (retire) begin
                            head_q <= '0;
                            occ_q  <= 2'd0;
                        end
                    end
                    2'd2: begin
                        // Full: nothing can be accepted, so a retire just promotes the skid entry.
                        if (retire) begin
                            head_q <= skid_q;
                            skid_q <= '0;
                            occ_q  <= 2'd1;
                        end
                    end
                    default: occ_q <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Self-checking bench for mem_wb_skid: a queue scoreboard holds accepted entries in order
// and every cycle's outputs are compared against its head before the clock edge.
module tb_mem_wb_skid;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rd_data;
    logic [ADDR_W-1:0] in_rd_addr;
    logic              in_rd_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wb_rd_data;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic              wb_we;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  retire_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              en;
    } ent_t;

    ent_t             sb_q[$];
    logic [CNT_W-1:0] m_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd_data (in_rd_data),
        .in_rd_addr (in_rd_addr),
        .in_rd_en   (in_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_rd_data (wb_rd_data),
        .wb_rd_addr (wb_rd_addr),
        .wb_we      (wb_we),
        .occupancy  (occupancy),
        .retire_cnt (retire_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the scoreboard, then advance the model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                         input logic e, input logic ordy, input logic fl, input logic r,
                         input logic rs);
        int   sz;
        logic acc;
        logic ret;
        ent_t tmp;
        in_valid   = v;
        in_rd_data = d;
        in_rd_addr = a;
        in_rd_en   = e;
        out_ready  = ordy;
        flush      = fl;
        rdy        = r;
        rst        = rs;
        #1;
        sz = sb_q.size();
        check("in_ready",   in_ready,   r && sz < 2);
        check("out_valid",  out_valid,  sz > 0);
        check("occupancy",  occupancy,  sz);
        check("retire_cnt", retire_cnt, m_cnt);
        if (sz > 0) begin
            check("wb_rd_data", wb_rd_data, sb_q[0].data);
            check("wb_rd_addr", wb_rd_addr, sb_q[0].addr);
            check("wb_we", wb_we, r && ordy && sb_q[0].en && (sb_q[0].addr != 0));
        end else begin
            check("wb_rd_data_empty", wb_rd_data, 0);
            check("wb_rd_addr_empty", wb_rd_addr, 0);
            check("wb_we_empty", wb_we, 0);
        end
        acc = r && (sz < 2) && v && !fl;
        ret = r && (sz > 0) && ordy && !fl;
        @(posedge clk);
        if (rs) begin
            sb_q.delete();
            m_cnt = '0;
        end else if (r) begin
            if (fl) begin
                sb_q.delete();
            end else begin
                if (ret) begin
                    void'(sb_q.pop_front());
                    m_cnt = m_cnt + 1'b1;
                end
                if (acc) begin
                    tmp.data = d;
                    tmp.addr = a;
                    tmp.en   = e;
                    sb_q.push_back(tmp);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, ordy, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input logic ordy);
        cycle(1'b1, d, a, 1'b1, ordy, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_rd_data = '0; in_rd_addr = '0; in_rd_en = 1'b0; out_ready = 1'b0;
        m_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then single pass through an empty block.
        push(32'hDEADBEEF, 5'd5, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("single_pass_cnt", retire_cnt, 4'd1);

        // Backpressure: A and B fill the block, C is held off until space frees.
        push(32'h11, 5'd1, 1'b0);
        push(32'h22, 5'd2, 1'b0);
        push(32'h33, 5'd3, 1'b0);
        check("full_in_ready", in_ready, 1'b0);
        push(32'h33, 5'd3, 1'b1);
        push(32'h33, 5'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("backpressure_cnt", retire_cnt, 4'd4);

        // x0 destination retires without writing.
        push(32'h55, 5'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full with an entry on offer.
        push(32'h66, 5'd6, 1'b0);
        push(32'h77, 5'd7, 1'b0);
        cycle(1'b1, 32'h99, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_occ", occupancy, 2'd0);
        idle(1'b1);
        idle(1'b1);

        // Freeze: rdy low holds everything, flush included.
        push(32'hAA, 5'd10, 1'b0);
        cycle(1'b1, 32'hBB, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hBB, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hBB, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("freeze_occ", occupancy, 2'd1);
        idle(1'b1);

        // Reset in the middle of backpressure.
        push(32'hC1, 5'd12, 1'b0);
        push(32'hC2, 5'd13, 1'b0);
        cycle(1'b1, 32'hC3, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_occ", occupancy, 2'd0);
        check("rst_data", wb_rd_data, 32'h0);
        idle(1'b1);

        // Wrap: 17 retires on a 4-bit counter from zero.
        for (int i = 0; i < 18; i++) push($urandom, 5'(i), 1'b1);
        check("wrap_cnt", retire_cnt, 4'd1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0), 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
